// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmit-core handshake bundle for uart_tx_arbiter
//
// Purpose: groups the per-requester byte streams and the transmit-core
// tx_start/din/tx_done_tick handshake into one port.
// Ports (signals):
//   req_valid/req_data/req_last : requester byte streams, requester i on req_data[8i+7:8i]
//   req_ready                   : per-requester accept strobe
//   tx_start/tx_din             : start pulse and byte towards the transmit core
//   tx_done_tick                : frame-complete pulse from the transmit core
// Modports: master = clients plus transmit core, slave = arbiter.

interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_din;
    logic              tx_done_tick;

    modport master (
        output req_valid, req_data, req_last, tx_done_tick,
        input  req_ready, tx_start, tx_din
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done_tick,
        output req_ready, tx_start, tx_din
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin sharing of one UART transmitter
//
// Purpose: lets NREQ byte-stream requesters share one UART transmit core.
// A requester keeps the transmitter from its first byte until it sends a
// byte tagged last, or until it stalls IDLE_TO cycles between bytes.
// Ports:
//   clk      : system clock
//   reset    : asynchronous, active-high reset
//   bus      : requester streams and transmit-core handshake (slave view)
//   grant_id : index of the current owner, registered, held while idle
//   busy     : high whenever the arbiter is not idle

module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int IW      = 2,
    parameter int IDLE_TO = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_tx_arbiter_if.slave      bus,
    output logic [IW-1:0]         grant_id,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(IDLE_TO - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   last_ptr_q, last_ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [7:0]      din_q, din_d;
    logic            last_q, last_d;
    logic [15:0]     timer_q, timer_d;
    logic [NREQ-1:0] ready_c;
    logic [IW:0]     pick;
    logic            win_found;
    logic [IW-1:0]   win_idx;

    // Round-robin pick: offsets are visited from far to near so the nearest
    // valid index after ptr is the last one written and therefore wins.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [IW-1:0]   ptr);
        logic [IW:0] r;
        int          idx;
        r = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (valid[idx]) begin
                r = {1'b1, IW'(idx)};
            end
        end
        return r;
    endfunction

    always_comb begin
        pick      = rr_pick(bus.req_valid, last_ptr_q);
        win_found = pick[IW];
        win_idx   = pick[IW-1:0];
    end

    always_comb begin
        state_d    = state_q;
        last_ptr_d = last_ptr_q;
        grant_d    = grant_q;
        din_d      = din_q;
        last_d     = last_q;
        timer_d    = timer_q;
        ready_c    = '0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    ready_c[win_idx] = 1'b1;
                    din_d            = bus.req_data[8*win_idx +: 8];
                    last_d           = bus.req_last[win_idx];
                    grant_d          = win_idx;
                    state_d          = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.tx_done_tick) begin
                    if (last_q) begin
                        last_ptr_d = grant_q;
                        state_d    = IDLE;
                    end else begin
                        timer_d = '0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Owner keeps the lock: its next byte skips arbitration.
                ready_c[grant_q] = 1'b1;
                if (bus.req_valid[grant_q]) begin
                    din_d   = bus.req_data[8*grant_q +: 8];
                    last_d  = bus.req_last[grant_q];
                    timer_d = '0;
                    state_d = START;
                end else if (timer_q == TIMER_LAST) begin
                    // Timer stays at this value, so it never wraps.
                    last_ptr_d = grant_q;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_ptr_q <= IW'(NREQ - 1);
            grant_q    <= '0;
            din_q      <= '0;
            last_q     <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            grant_q    <= grant_d;
            din_q      <= din_d;
            last_q     <= last_d;
            timer_q    <= timer_d;
        end
    end

    // Ready is combinational, so it is masked while reset is held to keep
    // requesters from handing over bytes that would be dropped.
    assign bus.req_ready = reset ? '0 : ready_c;
    assign bus.tx_start  = (state_q == START);
    assign bus.tx_din    = din_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] grant_id;
    logic       busy;
    int         n_checks = 0;
    int         n_errors = 0;
    int         start_cnt = 0;
    int         snap;

    uart_tx_arbiter_if #(.NREQ(4)) bus ();

    uart_tx_arbiter #(.NREQ(4), .IW(2), .IDLE_TO(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.tx_start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic done_pulse();
        bus.tx_done_tick = 1'b1;
        tick();
        bus.tx_done_tick = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic l);
        bus.req_data[8*i +: 8] = d;
        bus.req_last[i]        = l;
    endtask

    initial begin
        bus.req_valid    = 4'b1111;
        bus.req_data     = '0;
        bus.req_last     = '0;
        bus.tx_done_tick = 1'b0;

        // Reset state, with every requester valid to show ready stays low.
        tick();
        tick();
        settle();
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'h0);
        chk("rst_tx_din", 32'(bus.tx_din), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        bus.req_valid = 4'b0000;
        tick();
        reset = 1'b0;

        // Single byte from requester 0; tx_done_tick during START is ignored.
        set_req(0, 8'h41, 1'b1);
        bus.req_valid = 4'b0001;
        settle();
        chk("t1_ready", 32'(bus.req_ready), 32'h1);
        chk("t1_busy_idle", 32'(busy), 32'h0);
        tick();
        bus.req_valid    = 4'b0000;
        bus.tx_done_tick = 1'b1;
        settle();
        chk("t1_tx_start", 32'(bus.tx_start), 32'h1);
        chk("t1_tx_din", 32'(bus.tx_din), 32'h41);
        chk("t1_grant", 32'(grant_id), 32'h0);
        chk("t1_busy_start", 32'(busy), 32'h1);
        chk("t1_ready_start", 32'(bus.req_ready), 32'h0);
        tick();
        bus.tx_done_tick = 1'b0;
        settle();
        chk("t1_start_once", 32'(bus.tx_start), 32'h0);
        chk("t1_busy_wait", 32'(busy), 32'h1);
        tick();
        done_pulse();
        settle();
        chk("t1_busy_done", 32'(busy), 32'h0);

        // Packet lock: requester 1 sends 10,11,12 while requester 0 waits.
        set_req(1, 8'h10, 1'b0);
        set_req(0, 8'h30, 1'b1);
        bus.req_valid = 4'b0011;
        settle();
        chk("t3_ready_b0", 32'(bus.req_ready), 32'h2);
        tick();
        set_req(1, 8'h11, 1'b0);
        settle();
        chk("t3_start_b0", 32'(bus.tx_start), 32'h1);
        chk("t3_din_b0", 32'(bus.tx_din), 32'h10);
        chk("t3_grant_b0", 32'(grant_id), 32'h1);
        tick();
        settle();
        chk("t3_ready_wait", 32'(bus.req_ready), 32'h0);
        done_pulse();
        settle();
        chk("t3_ready_hold1", 32'(bus.req_ready), 32'h2);
        tick();
        set_req(1, 8'h12, 1'b1);
        settle();
        chk("t3_start_b1", 32'(bus.tx_start), 32'h1);
        chk("t3_din_b1", 32'(bus.tx_din), 32'h11);
        chk("t3_grant_b1", 32'(grant_id), 32'h1);
        tick();
        done_pulse();
        settle();
        chk("t3_ready_hold2", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 4'b0001;
        settle();
        chk("t3_din_b2", 32'(bus.tx_din), 32'h12);
        chk("t3_grant_b2", 32'(grant_id), 32'h1);
        tick();
        done_pulse();
        settle();
        chk("t3_ready_next", 32'(bus.req_ready), 32'h1);
        chk("t3_grant_held", 32'(grant_id), 32'h1);
        tick();
        bus.req_valid = 4'b0000;
        settle();
        chk("t3_grant_next", 32'(grant_id), 32'h0);
        chk("t3_din_next", 32'(bus.tx_din), 32'h30);
        tick();
        done_pulse();

        // Simultaneous requests 0 and 2 straight after reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        snap = start_cnt;
        set_req(0, 8'h20, 1'b1);
        set_req(2, 8'h22, 1'b1);
        bus.req_valid = 4'b0101;
        settle();
        chk("t2_ready_first", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b0100;
        settle();
        chk("t2_din_first", 32'(bus.tx_din), 32'h20);
        chk("t2_ready_start", 32'(bus.req_ready), 32'h0);
        tick();
        done_pulse();
        settle();
        chk("t2_ready_second", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'b0000;
        settle();
        chk("t2_grant_second", 32'(grant_id), 32'h2);
        chk("t2_din_second", 32'(bus.tx_din), 32'h22);
        tick();
        done_pulse();
        settle();
        chk("t2_start_count", 32'(start_cnt - snap), 32'd2);

        // Timeout: requester 3 stalls mid-packet, requester 0 pending.
        set_req(3, 8'hA5, 1'b0);
        bus.req_valid = 4'b1000;
        settle();
        chk("t4_ready_first", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        done_pulse();
        set_req(0, 8'h55, 1'b1);
        bus.req_valid = 4'b0001;
        settle();
        chk("t4_ready_hold", 32'(bus.req_ready), 32'h8);
        for (int i = 0; i < 7; i++) tick();
        settle();
        chk("t4_busy_hold_end", 32'(busy), 32'h1);
        tick();
        settle();
        chk("t4_busy_released", 32'(busy), 32'h0);
        chk("t4_ready_after", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b0000;
        settle();
        chk("t4_grant_after", 32'(grant_id), 32'h0);
        chk("t4_din_after", 32'(bus.tx_din), 32'h55);
        tick();
        done_pulse();

        // Fairness: all requesters always valid, one-byte packets.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 8'(8'h60 + i), 1'b1);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk($sformatf("t5_ready_%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
            tick();
            settle();
            chk($sformatf("t5_grant_%0d", k), 32'(grant_id), 32'(k % 4));
            chk($sformatf("t5_din_%0d", k), 32'(bus.tx_din), 32'(8'h60 + k % 4));
            tick();
            done_pulse();
        end

        // Reset mid-frame while requester 2 owns the transmitter.
        bus.req_valid = 4'b0100;
        set_req(2, 8'h77, 1'b1);
        set_req(0, 8'h01, 1'b1);
        settle();
        chk("t6_ready_own", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = 4'b0000;
        settle();
        chk("t6_grant_own", 32'(grant_id), 32'h2);
        tick();
        settle();
        chk("t6_busy_wait", 32'(busy), 32'h1);
        reset = 1'b1;
        #1;
        chk("t6_rst_tx_start", 32'(bus.tx_start), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_grant", 32'(grant_id), 32'h0);
        chk("t6_rst_din", 32'(bus.tx_din), 32'h0);
        bus.req_valid = 4'b0101;
        #1;
        chk("t6_rst_ready", 32'(bus.req_ready), 32'h0);
        tick();
        reset = 1'b0;
        settle();
        chk("t6_ready_after", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 4'b0000;
        settle();
        chk("t6_grant_after", 32'(grant_id), 32'h0);
        chk("t6_din_after", 32'(bus.tx_din), 32'h01);
        tick();
        done_pulse();
        settle();
        chk("t6_busy_end", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one serial transmitter between NREQ byte-stream requesters. It sits between client logic and the UART transmit core, which has a tx_start/din/tx_done_tick handshake. Arbitration is round-robin at packet granularity: a requester keeps the transmitter until it sends a byte tagged last, or until it stalls longer than a timeout.

Parameters:
NREQ, 4, number of requesters (legal range 2..8)
IW, 2, width of grant_id; must equal clog2(NREQ)
IDLE_TO, 1024, clk cycles the owner may stall between packet bytes before its lock is released (legal range 2..65535)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester byte valid
req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NREQ  byte is the final byte of its packet
req_ready  out  NREQ  byte accepted this cycle when valid&ready
tx_start  out  1  one-cycle start pulse to the transmit core
tx_din  out  8  byte to transmit; registered
tx_done_tick  in  1  one-cycle pulse from the transmit core when a frame completes
grant_id  out  IW  index of the current owner; registered
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: state=IDLE; tx_start=0; tx_din=0; grant_id=0; busy=0; req_ready=0; last_ptr=NREQ-1, so requester 0 wins first; hold timer=0; latched last flag=0.
- Reset asserted mid-operation returns the block to reset values immediately. Any in-flight byte is abandoned. No req_ready or tx_start pulse occurs while reset is high.
- States: IDLE, START, WAIT, HOLD.
- IDLE:
  - Scan indices last_ptr+1, last_ptr+2, ... modulo NREQ. The winner is the first index with req_valid=1.
  - req_ready[winner]=1 combinationally in the same cycle; all other ready bits are 0.
  - On transfer: latch req_data into tx_din, latch req_last, set grant_id=winner, go to START.
- START: tx_start=1 for exactly this one cycle; go to WAIT. tx_din stays stable from START until the next accepted byte.
- WAIT: ignore all req_valid; req_ready=0.
  - On tx_done_tick with latched last=1: set last_ptr=grant_id, go to IDLE.
  - On tx_done_tick with latched last=0: clear the timer, go to HOLD.
- HOLD: only the owner can be accepted; req_ready[grant_id]=1 and all others are 0.
  - If the owner has req_valid=1: transfer, latch data and last, go to START, timer=0.
  - Else if timer==IDLE_TO-1: release the lock (last_ptr=grant_id), go to IDLE.
  - Else: timer+1.
- Latency: a byte accepted in cycle N gives tx_start in cycle N+1. At most one byte is outstanding.
- Between packets a requester goes at least one IDLE cycle (entering IDLE, then its transfer cycle) before its next packet can start. In HOLD the next byte is taken without re-arbitration.
- tx_done_tick outside WAIT is ignored.
- Non-owner valid bits may be held indefinitely. Requesters must keep valid, data and last stable until ready.
- grant_id holds its last value in IDLE.
- Timer is 16 bits and never wraps; it saturates at the release point.

Test Plan:
1. Single byte: req_valid=0001, data0=0x41, last=1 -> req_ready=0001 in the same cycle; tx_start 1 cycle later with tx_din=0x41; busy until tx_done_tick; then IDLE, last_ptr=0.
2. Simultaneous requests: valid=0101, all last=1, starting from reset -> requester 0 sent first (0x..), then requester 2; exactly two tx_start pulses, in order 0 then 2.
3. Packet lock: requester 1 sends 0x10, 0x11, 0x12 with last on 0x12 while requester 0 is valid throughout -> the three bytes go out back-to-back, grant_id=1 throughout; requester 0 is served next.
4. Timeout: requester 3 sends 0xA5 with last=0, then drops valid, IDLE_TO=8 -> HOLD lasts 8 cycles, then IDLE; a pending requester 0 is granted next.
5. Fairness: all four requesters continuously valid, 1-byte packets -> grant order 0, 1, 2, 3, 0, 1; no requester granted twice in a row.
6. Reset mid-frame: assert reset in WAIT -> tx_start=0, busy=0, grant_id=0 immediately; after release, requester 0 wins first even if requester 2 was the previous owner.
